// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl_if
// Purpose  : Signal bundle between the stopwatch controller, the front-panel
//            buttons, the BCD counter and the 7-segment display driver.
// Revision : 1.0 - initial release
// ============================================================================
interface stopwatch_ctrl_if;
  logic        btn_ss;      // raw start/stop button
  logic        btn_lc;      // raw lap/clear button
  logic [15:0] cnt_bcd;     // counter digits {ones, tenths, hundredths, thousandths}
  logic        count_en_n;  // active-low count strobe
  logic        count_clr;   // synchronous counter clear pulse
  logic [15:0] disp_bcd;    // digits to the display driver
  logic        running;
  logic        lap_active;
  logic        overflow;

  // Controller side
  modport master (
    input  btn_ss, btn_lc, cnt_bcd,
    output count_en_n, count_clr, disp_bcd, running, lap_active, overflow
  );

  // Board / counter / display side
  modport slave (
    output btn_ss, btn_lc, cnt_bcd,
    input  count_en_n, count_clr, disp_bcd, running, lap_active, overflow
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Control FSM for a 4-digit BCD stopwatch: button debouncing,
//            start/stop/lap/clear sequencing, 1 ms count strobe generation,
//            live/frozen display bus and sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int CLK_DIV         = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  wire logic        clk,
  input  wire logic        reset,
  stopwatch_ctrl_if.master sw
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1
  localparam int c_DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int c_PS_W = $clog2(CLK_DIV);
  localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_LAP    = 2'd2,
    ST_PAUSED = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Button conditioning: bit 0 = start/stop, bit 1 = lap/clear
  // --------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] btn_evt;

  assign btn_raw = {sw.btn_lc, sw.btn_ss};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic              sync1_q, sync2_q;
    logic              level_q, level_d;
    logic              prev_q;
    logic              evt_q;
    logic [c_DB_W-1:0] cnt_q, cnt_d;

    // Stability counter: level flips after DEBOUNCE_CYCLES differing samples in a row
    always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
        if (cnt_q == c_DB_LAST) begin
          level_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Synchronizer, debounce state and registered rising-edge press pulse
    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        level_q <= 1'b0;
        cnt_q   <= '0;
        prev_q  <= 1'b0;
        evt_q   <= 1'b0;
      end else begin
        sync1_q <= btn_raw[b];
        sync2_q <= sync1_q;
        level_q <= level_d;
        cnt_q   <= cnt_d;
        prev_q  <= level_q;
        evt_q   <= level_q & ~prev_q;
      end
    end

    assign btn_evt[b] = evt_q;
  end

  // --------------------------------------------------------------------------
  // Sequencing FSM, prescaler, display and overflow
  // --------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [c_PS_W-1:0] presc_q, presc_d;
  logic              count_en_n_q;
  logic              count_clr_q, count_clr_d;
  logic [15:0]       disp_q, disp_d;
  logic              running_q, running_d;
  logic              lap_q, lap_d;
  logic              ovf_q, ovf_d;
  logic              tick_d;
  logic              ss_ev, lc_ev;
  logic              counting_q;

  // Start/stop wins when both buttons fire in the same cycle
  assign ss_ev      = btn_evt[0];
  assign lc_ev      = btn_evt[1] & ~btn_evt[0];
  assign counting_q = (state_q == ST_RUN) || (state_q == ST_LAP);

  // Next state plus the registered-output next values
  always_comb begin
    state_d     = state_q;
    count_clr_d = 1'b0;
    ovf_d       = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (ss_ev) begin
          state_d = ST_RUN;
        end else if (lc_ev) begin
          count_clr_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (ss_ev) begin
          state_d = ST_PAUSED;
        end else if (lc_ev) begin
          state_d = ST_LAP;
        end
      end
      ST_LAP: begin
        if (ss_ev) begin
          state_d = ST_PAUSED;
        end else if (lc_ev) begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSED: begin
        if (ss_ev) begin
          state_d = ST_RUN;
        end else if (lc_ev) begin
          state_d     = ST_IDLE;
          count_clr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    running_d = (state_d == ST_RUN) || (state_d == ST_LAP);
    lap_d     = (state_d == ST_LAP);

    // Prescaler runs while counting, holds in PAUSED so the ms phase survives
    if (state_d == ST_IDLE) begin
      presc_d = '0;
    end else if (counting_q) begin
      presc_d = (presc_q == c_PS_LAST) ? '0 : presc_q + 1'b1;
    end else begin
      presc_d = presc_q;
    end

    // Strobe is low in the cycle whose prescaler value is the last one
    tick_d = running_d && (presc_d == c_PS_LAST);

    // Entering or staying in LAP keeps the current display value frozen
    disp_d = (state_d == ST_LAP) ? disp_q : sw.cnt_bcd;

    if ((state_q == ST_PAUSED) && lc_ev) begin
      ovf_d = 1'b0;
    end else if (!count_en_n_q && (sw.cnt_bcd == 16'h9999)) begin
      ovf_d = 1'b1;
    end
  end

  // State and output registers; counter is held cleared while reset is high
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      count_en_n_q <= 1'b1;
      count_clr_q  <= 1'b1;
      disp_q       <= '0;
      running_q    <= 1'b0;
      lap_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      count_en_n_q <= ~tick_d;
      count_clr_q  <= count_clr_d;
      disp_q       <= disp_d;
      running_q    <= running_d;
      lap_q        <= lap_d;
      ovf_q        <= ovf_d;
    end
  end

  assign sw.count_en_n = count_en_n_q;
  assign sw.count_clr  = count_clr_q;
  assign sw.disp_bcd   = disp_q;
  assign sw.running    = running_q;
  assign sw.lap_active = lap_q;
  assign sw.overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Purpose  : Directed self-checking bench for stopwatch_ctrl with a BCD
//            counter model (CLK_DIV=4, DEBOUNCE_CYCLES=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pre_en;
  logic [15:0] pre_val;
  logic [15:0] cnt_model = 16'h0000;
  int          cyc;
  int          n_vec = 0;
  int          n_err = 0;
  int          lows;
  int          bad;

  stopwatch_ctrl_if sw ();

  stopwatch_ctrl #(
    .CLK_DIV         (4),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw)
  );

  always #5 clk = ~clk;

  // 4-digit BCD increment with wrap 9999 -> 0000
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Counter model: clear, then preload, then count on the strobe
  always @(posedge clk) begin
    if (sw.count_clr === 1'b1) begin
      cnt_model <= 16'h0000;
    end else if (pre_en) begin
      cnt_model <= pre_val;
    end else if (sw.count_en_n === 1'b0) begin
      cnt_model <= bcd_inc(cnt_model);
    end
  end

  assign sw.cnt_bcd = cnt_model;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step(1);
  endtask

  initial begin
    reset     = 1'b1;
    sw.btn_ss = 1'b0;
    sw.btn_lc = 1'b0;
    pre_en    = 1'b0;
    pre_val   = 16'h0000;
    cyc       = 0;

    // Reset state
    step(3);
    check_val("rst_count_clr",  16'(sw.count_clr),  16'h1);
    check_val("rst_count_en_n", 16'(sw.count_en_n), 16'h1);
    check_val("rst_disp",       sw.disp_bcd,        16'h0000);
    check_val("rst_running",    16'(sw.running),    16'h0);
    check_val("rst_lap",        16'(sw.lap_active), 16'h0);
    check_val("rst_overflow",   16'(sw.overflow),   16'h0);
    reset = 1'b0;
    step(1);
    check_val("post_rst_clr", 16'(sw.count_clr), 16'h0);
    lows = 0;
    bad  = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (sw.count_en_n !== 1'b1) lows++;
      if (sw.running !== 1'b0) bad++;
    end
    check_val("idle_no_ticks",   16'(lows), 16'd0);
    check_val("idle_not_running", 16'(bad), 16'd0);

    // Start and count: raw edge in cycle 0, event in cycle 6
    cyc = 0;
    sw.btn_ss = 1'b1;
    step_to(6);
    sw.btn_ss = 1'b0;
    check_val("start_run_before", 16'(sw.running), 16'h0);
    step_to(7);
    check_val("start_run_after",  16'(sw.running), 16'h1);
    step_to(9);
    check_val("first_tick_pre",   16'(sw.count_en_n), 16'h1);
    step_to(10);
    check_val("first_tick",       16'(sw.count_en_n), 16'h0);
    step_to(11);
    check_val("first_tick_width", 16'(sw.count_en_n), 16'h1);
    lows = 0;
    while (cyc < 26) begin
      step(1);
      if (sw.count_en_n === 1'b0) lows++;
    end
    check_val("tick_rate", 16'(lows), 16'd4);
    step_to(47);
    check_val("disp_0009", sw.disp_bcd, 16'h0009);
    step_to(48);
    check_val("disp_0010", sw.disp_bcd, 16'h0010);

    // Bounce rejection: toggle every 2 cycles from 49, stable high at 69
    step_to(49);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      sw.btn_ss = (i % 2 == 0);
      for (int k = 0; k < 2; k++) begin
        step(1);
        if (sw.running !== 1'b1) bad++;
      end
    end
    sw.btn_ss = 1'b1;
    while (cyc < 75) begin
      step(1);
      if (sw.running !== 1'b1) bad++;
    end
    check_val("bounce_no_event", 16'(bad), 16'd0);
    step_to(76);
    sw.btn_ss = 1'b0;
    check_val("bounce_paused", 16'(sw.running), 16'h0);
    step_to(80);
    check_val("paused_disp", sw.disp_bcd, 16'h0017);
    lows = 0;
    while (cyc < 96) begin
      step(1);
      if (sw.count_en_n === 1'b0) lows++;
    end
    check_val("paused_no_ticks", 16'(lows), 16'd0);

    // Resume from PAUSED: held prescaler phase gives tick at E+3
    step_to(97);
    sw.btn_ss = 1'b1;
    step_to(103);
    sw.btn_ss = 1'b0;
    step_to(104);
    check_val("resume_running", 16'(sw.running), 16'h1);
    step_to(105);
    check_val("resume_tick_pre", 16'(sw.count_en_n), 16'h1);
    step_to(106);
    check_val("resume_phase_tick", 16'(sw.count_en_n), 16'h0);

    // Lap freeze at 0123
    step_to(107);
    sw.btn_lc = 1'b1;
    step_to(110);
    pre_val = 16'h0123;
    pre_en  = 1'b1;
    step_to(111);
    pre_en  = 1'b0;
    step_to(113);
    sw.btn_lc = 1'b0;
    check_val("lap_pre_flag", 16'(sw.lap_active), 16'h0);
    check_val("lap_pre_disp", sw.disp_bcd, 16'h0123);
    step_to(114);
    check_val("lap_flag",     16'(sw.lap_active), 16'h1);
    check_val("lap_running",  16'(sw.running),    16'h1);
    check_val("lap_tick",     16'(sw.count_en_n), 16'h0);
    step_to(120);
    check_val("lap_frozen",   sw.disp_bcd, 16'h0123);
    step_to(121);
    sw.btn_lc = 1'b1;
    step_to(127);
    sw.btn_lc = 1'b0;
    step_to(128);
    check_val("lap_exit_flag", 16'(sw.lap_active), 16'h0);
    check_val("lap_exit_disp", sw.disp_bcd, 16'h0127);
    check_val("lap_exit_run",  16'(sw.running), 16'h1);

    // Wrap 9999 -> 0000 sets overflow
    step_to(130);
    pre_val = 16'h9999;
    pre_en  = 1'b1;
    step_to(131);
    pre_en  = 1'b0;
    step_to(134);
    check_val("wrap_pre_ovf",  16'(sw.overflow), 16'h0);
    check_val("wrap_pre_disp", sw.disp_bcd, 16'h9999);
    step_to(135);
    check_val("wrap_ovf", 16'(sw.overflow), 16'h1);
    step_to(136);
    check_val("wrap_disp_0000", sw.disp_bcd, 16'h0000);
    step_to(140);
    check_val("wrap_disp_0001", sw.disp_bcd, 16'h0001);

    // Simultaneous ss and lc in RUN -> PAUSED, no snapshot, no clear
    step_to(141);
    sw.btn_ss = 1'b1;
    sw.btn_lc = 1'b1;
    step_to(147);
    sw.btn_ss = 1'b0;
    sw.btn_lc = 1'b0;
    step_to(148);
    check_val("both_running", 16'(sw.running),    16'h0);
    check_val("both_lap",     16'(sw.lap_active), 16'h0);
    check_val("both_clr",     16'(sw.count_clr),  16'h0);
    check_val("both_disp",    sw.disp_bcd,        16'h0003);
    check_val("both_ovf",     16'(sw.overflow),   16'h1);

    // lc from PAUSED -> IDLE: one-cycle clear and overflow cleared
    step_to(155);
    sw.btn_lc = 1'b1;
    step_to(161);
    sw.btn_lc = 1'b0;
    check_val("clr_before",     16'(sw.count_clr), 16'h0);
    check_val("ovf_before_clr", 16'(sw.overflow),  16'h1);
    step_to(162);
    check_val("clr_pulse",      16'(sw.count_clr), 16'h1);
    check_val("ovf_cleared",    16'(sw.overflow),  16'h0);
    check_val("idle_running",   16'(sw.running),   16'h0);
    step_to(163);
    check_val("clr_width",      16'(sw.count_clr), 16'h0);
    step_to(164);
    check_val("clr_disp",       sw.disp_bcd, 16'h0000);

    // Start from IDLE: prescaler restarts, first tick at E+4
    step_to(170);
    sw.btn_ss = 1'b1;
    step_to(176);
    sw.btn_ss = 1'b0;
    step_to(177);
    check_val("restart_running", 16'(sw.running), 16'h1);
    step_to(179);
    check_val("restart_tick_pre", 16'(sw.count_en_n), 16'h1);
    step_to(180);
    check_val("restart_tick", 16'(sw.count_en_n), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM for the 4-digit BCD stopwatch counter (ones / tenths / hundredths / thousandths). It debounces the two front-panel buttons and sequences start, stop, lap and clear. It generates the 1 kHz count strobe on the counter's active-low enable, and drives a display bus that is either live or frozen for a lap. It sits between the board buttons, the counter and the 7-segment display driver.

## Interface
Parameters:
- CLK_DIV, 50000: clk cycles per count tick (50 MHz -> 1 ms); legal range >= 2.
- DEBOUNCE_CYCLES, 500000: consecutive stable samples required before a button level is accepted; legal range >= 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- btn_ss  in  1  start/stop button, raw, active-high, asynchronous.
- btn_lc  in  1  lap/clear button, raw, active-high, asynchronous.
- cnt_bcd  in  16  counter digits {ones, tenths, hundredths, thousandths}, 4 bits each.
- count_en_n  out  1  counter enable, active-low; low for exactly one cycle per tick.
- count_clr  out  1  synchronous clear to the counter; one-cycle pulse.
- disp_bcd  out  16  digits to the display driver.
- running  out  1  high in RUN or LAP.
- lap_active  out  1  high in LAP.
- overflow  out  1  sticky; set when the counter wraps 9.999 -> 0.000.

## Operation
- Button path, per button:
  - 2-flop synchronizer.
  - Stability counter: the debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from the current debounced level. Any bounce restarts the count.
  - Press event: one-cycle pulse on the 0->1 edge of the debounced level. Release generates no event.
- States: IDLE, RUN, LAP, PAUSED. Transitions:
  - IDLE: ss -> RUN. lc -> IDLE, pulses count_clr.
  - RUN: ss -> PAUSED. lc -> LAP, snapshot taken.
  - LAP: ss -> PAUSED, snapshot released. lc -> RUN, snapshot released.
  - PAUSED: ss -> RUN. lc -> IDLE, pulses count_clr and clears overflow.
- Simultaneous ss and lc events in the same cycle: ss is taken and lc is discarded.
- Prescaler (0..CLK_DIV-1):
  - Increments only in RUN and LAP; holds its value in PAUSED.
  - Forced to 0 in IDLE and on reset.
  - When it reaches CLK_DIV-1 it wraps to 0 and count_en_n is driven low for that cycle.
  - Pausing therefore preserves the sub-millisecond phase.
- Display:
  - In IDLE, RUN and PAUSED, disp_bcd is cnt_bcd registered (1-cycle lag).
  - In LAP, disp_bcd holds the snapshot.
- Overflow: set when a tick is issued while cnt_bcd == 16'h9999. It stays set until the lc-driven PAUSED -> IDLE clear or reset. Counting continues from 0.000 after the wrap.
- Reset values:
  - State IDLE; prescaler 0; debouncers' levels and counters 0.
  - count_en_n = 1, count_clr = 1 (the counter is cleared while reset is held), disp_bcd = 0.
  - running = 0, lap_active = 0, overflow = 0.
  - count_clr drops to 0 on the first edge with reset low.
- Reset mid-operation: all of the above apply immediately at the reset edge, regardless of state, pending events or debounce progress.

## Timing
- Button latency: a raw level change that stays stable produces its event pulse 2 (sync) + DEBOUNCE_CYCLES + 1 cycles later.
- Event in cycle E:
  - State, running and lap_active are updated in cycle E+1.
  - The count_clr pulse is high in cycle E+1 only.
- Lap snapshot equals the disp_bcd value present in cycle E, i.e. cnt_bcd of cycle E-1. disp_bcd holds that value from E+1.
- Tick timing:
  - First tick after IDLE -> RUN: count_en_n is low in cycle E+CLK_DIV.
  - Subsequent ticks follow every CLK_DIV cycles while the state is RUN or LAP.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
All scenarios use CLK_DIV=4 and DEBOUNCE_CYCLES=3.
- Reset then idle: hold reset 3 cycles, release -> count_clr high during reset and low after; count_en_n stays 1 for 50 cycles; running=0.
- Start and count: clean ss press -> event 6 cycles after the raw edge; running=1 next cycle; count_en_n low for 1 cycle every 4 cycles; with a live counter model, disp_bcd reaches 16'h0010 after 40 cycles of RUN.
- Bounce rejection: btn_ss toggles every 2 cycles for 20 cycles, then stays high -> exactly one event, 6 cycles after the final edge; no event during the toggling.
- Lap freeze: in RUN at count 16'h0123, press lc -> lap_active=1 and disp_bcd holds 16'h0123 while ticks continue; press lc again -> disp_bcd goes live and lap_active=0.
- Pause/clear: RUN, then ss -> PAUSED, no ticks and prescaler held; then lc -> IDLE with count_clr high exactly 1 cycle; then ss -> first tick 4 cycles after the event.
- Wrap and priority:
  - Preload the counter model to 16'h9999 in RUN -> the next tick wraps to 0 and overflow=1; overflow stays 1 until the PAUSED -> IDLE clear.
  - ss and lc events in the same cycle while in RUN -> state becomes PAUSED, with no snapshot and no clear.
